// File: rtl/byte_word_packer.sv
// Packs a byte stream into RATIO-byte words (byte 0 in the low lane) with keep mask,
// last flag and a per-frame word address. Define BYTE_WORD_PACKER_FLUSH_EN to add an idle auto-flush.
module byte_word_packer #(
  parameter int RATIO        = 8,
  parameter int ADDR_W       = 9,
  parameter int FLUSH_CYCLES = 256
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_LAST,
  output logic                  IN_READY,
  output logic [8*RATIO-1:0]    OUT_DATA,
  output logic [RATIO-1:0]      OUT_KEEP,
  output logic                  OUT_LAST,
  output logic [ADDR_W-1:0]     OUT_WADDR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (RATIO < 1 || FLUSH_CYCLES < 1) begin : g_bad_params
    $error("byte_word_packer: RATIO and FLUSH_CYCLES must be at least 1");
  end

  // Handshake: a byte moves on IN_VALID & IN_READY, a word moves on OUT_VALID & OUT_READY,
  // both at the rising edge; IN_READY never looks at IN_VALID or IN_LAST.
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [8*RATIO-1:0]     acc_q, acc_d;
  logic [8*RATIO-1:0]     out_data_q, out_data_d;
  logic [RATIO-1:0]       out_keep_q, out_keep_d;
  logic                   out_last_q, out_last_d;
  logic [ADDR_W-1:0]      out_waddr_q, out_waddr_d;
  logic                   out_valid_q, out_valid_d;

  logic                   slot_free;
  logic                   in_accept;
  logic                   word_done;
  logic                   out_take;
  logic                   flush_fire;
  logic [8*RATIO-1:0]     acc_merged;
  logic [RATIO-1:0]       keep_thru;

  assign slot_free = ~out_valid_q | OUT_READY;
  assign IN_READY  = RESETN & slot_free;
  assign in_accept = IN_VALID & IN_READY;
  assign word_done = (idx_q == IDX_W'(RATIO - 1)) | IN_LAST;
  assign out_take  = out_valid_q & OUT_READY;

  // Accumulator with the incoming byte dropped into lane idx; lanes above idx are already zero.
  always_comb begin
    acc_merged = acc_q;
    keep_thru  = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (IDX_W'(i) == idx_q) acc_merged[8*i +: 8] = IN_DATA;
      if (IDX_W'(i) <= idx_q) keep_thru[i] = 1'b1;
    end
  end

`ifdef BYTE_WORD_PACKER_FLUSH_EN
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [RATIO-1:0] keep_below;

  assign keep_below = keep_thru >> 1;
  assign flush_fire = (idle_cnt_q == CNT_W'(FLUSH_CYCLES)) && (idx_q != '0) &&
                      slot_free && !in_accept;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (in_accept || (idx_q == '0) || flush_fire) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != CNT_W'(FLUSH_CYCLES)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) idle_cnt_q <= '0;
    else         idle_cnt_q <= idle_cnt_d;
  end
`else
  assign flush_fire = 1'b0;
`endif

  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_waddr_d = out_waddr_q;
    out_valid_d = out_valid_q;

    if (out_take) begin
      out_valid_d = 1'b0;
      out_waddr_d = out_last_q ? '0 : out_waddr_q + 1'b1;
    end

    if (in_accept) begin
      if (word_done) begin
        out_data_d  = acc_merged;
        out_keep_d  = keep_thru;
        out_last_d  = IN_LAST;
        out_valid_d = 1'b1;
        idx_d       = '0;
        acc_d       = '0;
      end else begin
        acc_d = acc_merged;
        idx_d = idx_q + 1'b1;
      end
    end

`ifdef BYTE_WORD_PACKER_FLUSH_EN
    // A flush only fires when no byte is accepted, so it never competes with the branch above.
    if (flush_fire) begin
      out_data_d  = acc_q;
      out_keep_d  = keep_below;
      out_last_d  = 1'b0;
      out_valid_d = 1'b1;
      idx_d       = '0;
      acc_d       = '0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_waddr_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_waddr_q <= out_waddr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_KEEP  = out_keep_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_WADDR = out_waddr_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Randomized and directed bench for byte_word_packer: a byte-list model predicts each
// word (data, keep, last, word-in-frame address) and a scoreboard checks delivered words.
module tb_byte_word_packer;

  localparam int RATIO   = 8;
  localparam int ADDR_W  = 9;
  localparam int FLUSH_N = 16;
  localparam int EW      = 64 + 8 + 1 + ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]        in_data;
  logic              in_valid, in_last, in_ready;
  logic [63:0]       out_data;
  logic [7:0]        out_keep;
  logic              out_last, out_valid, out_ready;
  logic [ADDR_W-1:0] out_waddr;

  byte_word_packer #(.RATIO(RATIO), .ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH_N)) dut (
    .CLK(clk), .RESETN(rst_n),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_LAST(in_last), .IN_READY(in_ready),
    .OUT_DATA(out_data), .OUT_KEEP(out_keep), .OUT_LAST(out_last),
    .OUT_WADDR(out_waddr), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: bytes of the word being built, word index within the frame
  logic [7:0]    part_q[$];
  int            frame_word = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] make_word(input logic lst);
    logic [63:0] d = '0;
    logic [7:0]  k = '0;
    for (int i = 0; i < part_q.size(); i++) begin
      d[8*i +: 8] = part_q[i];
      k[i] = 1'b1;
    end
    return {d, k, lst, ADDR_W'(frame_word)};
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  bit            expect_valid = 0;
  bit            hold_pending = 0;
  logic [EW-1:0] hold_snap;
  bit            seen_valid   = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("in_ready_in_reset", in_ready, 1'b0);
      part_q.delete();
      exp_q.delete();
      frame_word   = 0;
      expect_valid = 0;
      hold_pending = 0;
    end else begin
      if (out_valid) seen_valid = 1;
      if (expect_valid) check_eq("latency_valid", out_valid, 1'b1);
      expect_valid = 0;
      if (hold_pending)
        check_eq("hold", {out_data, out_keep, out_last, out_waddr}, hold_snap[63:0]);
      check_eq("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_word", out_data, 64'hDEAD_0000_0000_0000 ^ out_data ^ 64'h1);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check_eq("out_data",  out_data,  e[EW-1 -: 64]);
          check_eq("out_keep",  out_keep,  e[ADDR_W+8 -: 8]);
          check_eq("out_last",  out_last,  e[ADDR_W]);
          check_eq("out_waddr", out_waddr, e[ADDR_W-1:0]);
        end
      end
      hold_pending = out_valid && !out_ready;
      hold_snap    = {out_data, out_keep, out_last, out_waddr};
      if (in_valid && in_ready) begin
        part_q.push_back(in_data);
        if (in_last || part_q.size() == RATIO) begin
          exp_q.push_back(make_word(in_last));
          expect_valid = 1;
          part_q.delete();
          frame_word = in_last ? 0 : (frame_word + 1) % (1 << ADDR_W);
        end
      end
    end
  end

  // downstream ready: 0 = always ready, 1 = random bounded runs, 2 = stalled
  int rdy_mode = 0;
  int rdy_run  = 0;
  always begin
    @(posedge clk); #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 2) out_ready = 1'b0;
    else if (rdy_run > 0) rdy_run--;
    else begin
      out_ready = !out_ready;
      rdy_run   = out_ready ? $urandom_range(1, 6) : $urandom_range(0, 3);
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    bit ok = 0;
    int n  = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) check_eq("accept_wait", ok, 1'b1);
  endtask

  task automatic idle_input();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_data",  out_data,  64'h0);
    check_eq("rst_keep",  out_keep,  8'h0);
    check_eq("rst_last",  out_last,  1'b0);
    check_eq("rst_waddr", out_waddr, '0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // full word, bytes 0x00..0x07 back-to-back
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b0, 0);
    idle_input();
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_data",  out_data,  64'h0706050403020100);
    check_eq("t1_keep",  out_keep,  8'hFF);
    check_eq("t1_waddr", out_waddr, '0);
    check_eq("t1_last",  out_last,  1'b0);
    wait_drain();

    // 16 bytes ending a frame
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), i == 15, 0);
    idle_input();
    wait_drain();

    // short frame: next frame restarts at address 0
    send_byte(8'hAA, 1'b0, 0);
    send_byte(8'hBB, 1'b0, 0);
    send_byte(8'hCC, 1'b1, 0);
    idle_input();
    check_eq("t3_data",  out_data,  64'h0000000000CCBBAA);
    check_eq("t3_keep",  out_keep,  8'h07);
    check_eq("t3_last",  out_last,  1'b1);
    check_eq("t3_waddr", out_waddr, '0);
    wait_drain();

    // single-byte frame
    send_byte(8'h5A, 1'b1, 1);
    idle_input();
    check_eq("t4_keep", out_keep, 8'h01);
    wait_drain();

    // backpressure: first word held, input stalls until the slot frees
    rdy_mode = 2; out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send_byte(8'(8'h60 + i), i == 15, 0);
        idle_input();
      end
      begin
        repeat (20) @(posedge clk);
        #2;
        check_eq("bp_in_ready", in_ready, 1'b0);
        check_eq("bp_valid",    out_valid, 1'b1);
        check_eq("bp_data",     out_data, 64'h6766656463626160);
        rdy_mode = 0;
      end
    join
    wait_drain();

    // reset mid-frame discards the partial word
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b0, 0);
    idle_input();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("mid_rst_valid", out_valid, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i), i == 7, 0);
    idle_input();
    check_eq("mid_rst_data",  out_data,  64'h4746454443424140);
    check_eq("mid_rst_waddr", out_waddr, '0);
    wait_drain();

    // partial word then idle
    seen_valid = 0;
    send_byte(8'h51, 1'b0, 0);
    send_byte(8'h52, 1'b0, 0);
    idle_input();
`ifdef BYTE_WORD_PACKER_FLUSH_EN
    exp_q.push_back(make_word(1'b0));
    part_q.delete();
    frame_word++;
    begin
      int n = 0;
      while (!out_valid && n < FLUSH_N + 10) begin @(posedge clk); #1; n++; end
      check_eq("flush_keep", out_keep, 8'h03);
      check_eq("flush_last", out_last, 1'b0);
      check_eq("flush_data", out_data, 64'h5251);
    end
    wait_drain();
`else
    repeat (3 * FLUSH_N) @(posedge clk);
    #1;
    check_eq("no_flush", seen_valid, 1'b0);
`endif
    send_byte(8'h53, 1'b1, 0);
    idle_input();
    wait_drain();

    // random frames with gaps and random backpressure
    rdy_mode = 1;
    for (int f = 0; f < 60; f++) begin
      int len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++)
        send_byte(8'($urandom_range(0, 255)), i == len - 1, $urandom_range(0, 2));
    end
    idle_input();
    rdy_mode = 0;
    wait_drain();

    // one long frame wraps the word address past 2^ADDR_W-1
    for (int i = 0; i < (520 * RATIO); i++) send_byte(8'($urandom_range(0, 255)), i == 520 * RATIO - 1, 0);
    idle_input();
    wait_drain();

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
